// File: rtl/rca_adder_pkg.sv
// Shared constants for the ripple-carry adder slice.
// RCA_GATE_DELAY_EN (optional) gives every primitive gate a unit delay.
package rca_adder_pkg;

    // Operand width used when the parent does not override N.
    localparam int RCA_DEFAULT_N = 16;

    // Delay of one primitive gate in simulation time units.
`ifdef RCA_GATE_DELAY_EN
    localparam int RCA_GATE_DLY = 1;
`else
    localparam int RCA_GATE_DLY = 0;
`endif

endpackage

// File: rtl/rca_adder_full_adder.sv
// One-bit full adder: the repeated stage of the ripple chain.
// Ports: a, b, ci in; s (sum), co (carry out), p (propagate) out.
// RCA_GATE_DELAY_EN adds a unit delay to every XOR/AND/OR gate.
module full_adder
    import rca_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co,
    output logic p
);

    logic g;
    logic pc;

`ifdef RCA_GATE_DELAY_EN
    // Each gate is modelled separately so the carry path costs
    // two gate delays per stage (AND then OR).
    assign #(RCA_GATE_DLY) p  = a ^ b;
    assign #(RCA_GATE_DLY) g  = a & b;
    assign #(RCA_GATE_DLY) s  = p ^ ci;
    assign #(RCA_GATE_DLY) pc = p & ci;
    assign #(RCA_GATE_DLY) co = g | pc;
`else
    assign p  = a ^ b;
    assign g  = a & b;
    assign s  = p ^ ci;
    assign pc = p & ci;
    assign co = g | pc;
`endif

endmodule

// File: rtl/rca_adder.sv
// N-bit ripple-carry adder with combinational S/Cout/P and a
// registered copy of {Cout, S}.
// Ports: clk, rst_n (async, active-low); A, B, Cin in;
//        S, Cout, P combinational out; S_q, Cout_q registered out.
// Macro: RCA_GATE_DELAY_EN enables unit gate delays in full_adder.
module rca_adder
    import rca_adder_pkg::*;
#(
    parameter int N = RCA_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic [N-1:0] P,
    output logic [N-1:0] S_q,
    output logic         Cout_q
);

    // c[i] is the carry into stage i; c[N] is the final carry out.
    logic [N:0]   c;
    logic [N-1:0] s_d;
    logic         cout_d;

    assign c[0] = Cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (S[i]),
            .co (c[i+1]),
            .p  (P[i])
        );
    end

    assign Cout = c[N];

    always_comb begin
        s_d    = S;
        cout_d = c[N];
    end

    // Reset clears only the register; the adder itself stays live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_q    <= '0;
            Cout_q <= 1'b0;
        end else begin
            S_q    <= s_d;
            Cout_q <= cout_d;
        end
    end

endmodule

// File: tb/tb_rca_adder.sv
// Self-checking bench for rca_adder (N = 16) against an
// arithmetic reference model.
module tb_rca_adder;
    import rca_adder_pkg::*;

    localparam int N      = 16;
    localparam int SETTLE = 2 * N + 1;
    localparam int NRAND  = 10000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] s;
    logic         cout;
    logic [N-1:0] p;
    logic [N-1:0] s_q;
    logic         cout_q;

    int tests_run = 0;
    int failed    = 0;

    always #50 clk = ~clk;

    rca_adder #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (a),
        .B      (b),
        .Cin    (cin),
        .S      (s),
        .Cout   (cout),
        .P      (p),
        .S_q    (s_q),
        .Cout_q (cout_q)
    );

    // Reference: exact N+1 bit sum.
    function automatic logic [N:0] ref_sum(input logic [N-1:0] x,
                                           input logic [N-1:0] y,
                                           input logic ci);
        return {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
    endfunction

    task automatic test_reset();
        logic [N:0] exp;
        rst_n = 1'b0;
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
        #SETTLE;
        tests_run++;
        if ({cout_q, s_q} !== 17'h0) begin
            failed++;
            $display("FAIL reset_reg got %h want 00000", {cout_q, s_q});
        end
        tests_run++;
        if ({cout, s} !== 17'h10000) begin
            failed++;
            $display("FAIL reset_comb got %h want 10000", {cout, s});
        end
        @(posedge clk); #1;
        tests_run++;
        if ({cout_q, s_q} !== 17'h0) begin
            failed++;
            $display("FAIL reset_hold got %h want 00000", {cout_q, s_q});
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp = ref_sum(a, b, cin);
        @(posedge clk); #1;
        tests_run++;
        if ({cout_q, s_q} !== exp) begin
            failed++;
            $display("FAIL reset_first_load got %h want %h",
                     {cout_q, s_q}, exp);
        end
    endtask

    task automatic test_full_ripple();
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; cin = 1'b1;
        #SETTLE;
        tests_run++;
        if ({cout, s} !== 17'h10000) begin
            failed++;
            $display("FAIL ripple_sum got %h want 10000", {cout, s});
        end
        tests_run++;
        if (p !== 16'hFFFF) begin
            failed++;
            $display("FAIL ripple_p got %h want ffff", p);
        end
`ifdef RCA_GATE_DELAY_EN
        begin
            int last_bad;
            @(negedge clk);
            cin = 1'b0;
            #SETTLE;
            cin = 1'b1;
            last_bad = 0;
            for (int t = 1; t <= SETTLE; t++) begin
                #(RCA_GATE_DLY);
                if ({cout, s} !== 17'h10000) last_bad = t;
            end
            tests_run++;
            if (last_bad < 2 * N - 3 || last_bad >= SETTLE) begin
                failed++;
                $display("FAIL ripple_settle last_bad %0d want %0d..%0d",
                         last_bad, 2 * N - 3, SETTLE - 1);
            end
        end
`endif
    endtask

    task automatic test_no_carry();
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0;
        #SETTLE;
        tests_run++;
        if ({cout, s} !== 17'h05555) begin
            failed++;
            $display("FAIL nocarry_sum got %h want 05555", {cout, s});
        end
        tests_run++;
        if (p !== 16'h5115) begin
            failed++;
            $display("FAIL nocarry_p got %h want 5115", p);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({cout_q, s_q} !== 17'h05555) begin
            failed++;
            $display("FAIL nocarry_reg got %h want 05555", {cout_q, s_q});
        end
    endtask

    task automatic test_max();
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        #SETTLE;
        tests_run++;
        if ({cout, s} !== 17'h1FFFF) begin
            failed++;
            $display("FAIL max_sum got %h want 1ffff", {cout, s});
        end
        tests_run++;
        if (p !== 16'h0000) begin
            failed++;
            $display("FAIL max_p got %h want 0000", p);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({cout_q, s_q} !== 17'h1FFFF) begin
            failed++;
            $display("FAIL max_reg got %h want 1ffff", {cout_q, s_q});
        end
    endtask

    task automatic test_random();
        logic [N:0] exp;
        logic [N:0] prev;
        int         prints;
        prints = 0;
        prev = ref_sum(a, b, cin);
        for (int i = 0; i < NRAND; i++) begin
            @(negedge clk);
            a   = N'($urandom);
            b   = N'($urandom);
            cin = 1'($urandom);
            if (i % 64 == 0) a = '1;
            if (i % 64 == 1) b = '1;
            exp = ref_sum(a, b, cin);
            #SETTLE;
            tests_run++;
            if ({cout, s} !== exp || p !== (a ^ b)) begin
                failed++;
                if (prints++ < 10)
                    $display("FAIL rand_comb a=%h b=%h ci=%b got %h/%h want %h/%h",
                             a, b, cin, {cout, s}, p, exp, a ^ b);
            end
            tests_run++;
            if ({cout_q, s_q} !== prev) begin
                failed++;
                if (prints++ < 10)
                    $display("FAIL rand_reg got %h want %h",
                             {cout_q, s_q}, prev);
            end
            prev = exp;
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (s_q !== 16'h5555) begin
            failed++;
            $display("FAIL midrst_pre got %h want 5555", s_q);
        end
        #20;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({cout_q, s_q} !== 17'h0) begin
            failed++;
            $display("FAIL midrst_clear got %h want 00000", {cout_q, s_q});
        end
        tests_run++;
        if (s !== 16'h5555) begin
            failed++;
            $display("FAIL midrst_comb got %h want 5555", s);
        end
        a = 16'h1111;
        @(negedge clk);
        rst_n = 1'b1;
        #10;
        tests_run++;
        if ({cout_q, s_q} !== 17'h0) begin
            failed++;
            $display("FAIL midrst_hold got %h want 00000", {cout_q, s_q});
        end
        @(posedge clk); #1;
        tests_run++;
        if ({cout_q, s_q} !== 17'h05432) begin
            failed++;
            $display("FAIL midrst_reload got %h want 05432", {cout_q, s_q});
        end
    endtask

    initial begin
        test_reset();
        test_full_ripple();
        test_no_carry();
        test_max();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
